// File: rtl/posit_encoder.sv
// Pipelined posit packer: builds regime | exp | frac from an unpacked posit, then rounds
// (nearest-even), saturates and applies the sign. Two register stages with valid/ready.
module posit_encoder #(
   parameter int unsigned BITS   = 32,
   parameter int unsigned ES     = 0,
   parameter int unsigned FRAC_W = 29
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sign,
   input  logic [BITS-1:0]              in_k,
   input  logic [(ES > 0 ? ES : 1)-1:0] in_exp,
   input  logic [FRAC_W-1:0]            in_frac,
   input  logic                         in_zero,
   input  logic                         in_nar,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BITS-1:0]              out_posit
);

   localparam int unsigned W   = BITS + ES + FRAC_W + 1;
   localparam int unsigned EfW = ES + FRAC_W;
   localparam int unsigned ShW = $clog2(W);
   localparam logic signed [BITS-1:0] KMax = BITS'(BITS - 2);
   localparam logic signed [BITS-1:0] KMin = -KMax;

   // Stage 1 state
   logic            s1_valid_q, s1_valid_d;
   logic [BITS-2:0] s1_body_q, s1_body_d;
   logic            s1_guard_q, s1_guard_d;
   logic            s1_sticky_q, s1_sticky_d;
   logic            s1_sign_q, s1_sign_d;
   logic            s1_zero_q, s1_zero_d;
   logic            s1_nar_q, s1_nar_d;
   logic            s1_sat_hi_q, s1_sat_hi_d;
   logic            s1_sat_lo_q, s1_sat_lo_d;

   // Stage 2 state
   logic            s2_valid_q, s2_valid_d;
   logic [BITS-1:0] s2_posit_q, s2_posit_d;

   logic            s2_adv;
   logic            s1_load;

   logic [EfW-1:0]  ef;
   logic            k_neg;
   logic [ShW-1:0]  sh;
   logic [W-1:0]    x;
   logic [W-1:0]    x_sh;
   logic            sat_hi;
   logic            sat_lo;

   logic            round_up;
   logic            carry;
   logic [BITS-2:0] body_inc;
   logic [BITS-2:0] body_fin;
   logic [BITS-1:0] mag;
   logic [BITS-1:0] posit_val;

   if (ES > 0) begin : g_exp
      assign ef = {in_exp, in_frac};
   end else begin : g_noexp
      logic unused_exp;
      assign unused_exp = ^in_exp;
      assign ef = in_frac;
   end

   assign s2_adv    = !s2_valid_q | out_ready;
   assign in_ready  = !s1_valid_q | s2_adv;
   assign s1_load   = in_valid & in_ready;
   assign out_valid = s2_valid_q;
   assign out_posit = s2_posit_q;

   // Seed pattern {1,0,...} sign-extends into a run of ones for k >= 0; {0,1,...} shifted by
   // -k-1 (= ~k) gives the run of zeros for k < 0. Saturated k leave sh meaningless.
   always_comb begin
      k_neg  = in_k[BITS-1];
      sh     = k_neg ? ~in_k[ShW-1:0] : in_k[ShW-1:0];
      x      = {~k_neg, k_neg, ef, {(BITS - 1){1'b0}}};
      x_sh   = W'($signed(x) >>> sh);
      sat_hi = $signed(in_k) > KMax;
      sat_lo = $signed(in_k) < KMin;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_body_d   = s1_body_q;
      s1_guard_d  = s1_guard_q;
      s1_sticky_d = s1_sticky_q;
      s1_sign_d   = s1_sign_q;
      s1_zero_d   = s1_zero_q;
      s1_nar_d    = s1_nar_q;
      s1_sat_hi_d = s1_sat_hi_q;
      s1_sat_lo_d = s1_sat_lo_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
      end
      if (s1_load) begin
         s1_body_d   = x_sh[W-1 -: BITS-1];
         s1_guard_d  = x_sh[W-BITS];
         s1_sticky_d = |x_sh[W-BITS-1:0];
         s1_sign_d   = in_sign;
         s1_zero_d   = in_zero;
         s1_nar_d    = in_nar;
         s1_sat_hi_d = sat_hi;
         s1_sat_lo_d = sat_lo;
      end
   end

   always_comb begin
      round_up          = s1_guard_q & (s1_sticky_q | s1_body_q[0]);
      {carry, body_inc} = {1'b0, s1_body_q} + BITS'(round_up);
      if (s1_sat_hi_q || carry) begin
         body_fin = '1;
      end else if (s1_sat_lo_q) begin
         body_fin = (BITS - 1)'(1);
      end else begin
         body_fin = body_inc;
      end
      mag = {1'b0, body_fin};
      if (s1_nar_q) begin
         posit_val = {1'b1, {(BITS - 1){1'b0}}};
      end else if (s1_zero_q) begin
         posit_val = '0;
      end else begin
         posit_val = s1_sign_q ? -mag : mag;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_posit_d = s2_posit_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_posit_d = posit_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_body_q   <= '0;
         s1_guard_q  <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_nar_q    <= 1'b0;
         s1_sat_hi_q <= 1'b0;
         s1_sat_lo_q <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_posit_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_body_q   <= s1_body_d;
         s1_guard_q  <= s1_guard_d;
         s1_sticky_q <= s1_sticky_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_nar_q    <= s1_nar_d;
         s1_sat_hi_q <= s1_sat_hi_d;
         s1_sat_lo_q <= s1_sat_lo_d;
         s2_valid_q  <= s2_valid_d;
         s2_posit_q  <= s2_posit_d;
      end
   end

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder at BITS=8, ES=0, FRAC_W=5: directed vector table,
// backpressure and reset sequences, and a randomized handshake run against a bit-serial model.
module tb_posit_encoder;

   localparam int NWORDS = 10000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_sign = 1'b0;
   logic [7:0] in_k = '0;
   logic [0:0] in_exp = '0;
   logic [4:0] in_frac = '0;
   logic       in_zero = 1'b0;
   logic       in_nar = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_posit;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic       sign;
      logic [7:0] k;
      logic [4:0] frac;
      logic       zero;
      logic       nar;
      logic [7:0] expv;
   } vec_t;

   vec_t       vecs[18];
   logic [7:0] sb[$];

   posit_encoder #(.BITS(8), .ES(0), .FRAC_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_k      (in_k),
      .in_exp    (in_exp),
      .in_frac   (in_frac),
      .in_zero   (in_zero),
      .in_nar    (in_nar),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_posit (out_posit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent model: emits the posit bit by bit, then rounds on the truncated stream.
   function automatic logic [7:0] model(input logic s, input logic [7:0] k, input logic [4:0] f,
                                        input logic z, input logic n);
      logic       stream [0:31];
      int         len;
      int         ki;
      logic [6:0] mag;
      logic       guard;
      logic       sticky;
      logic [7:0] p;
      ki = int'($signed(k));
      if (n) return 8'h80;
      if (z) return 8'h00;
      if (ki > 6) begin
         mag = 7'h7F;
      end else if (ki < -6) begin
         mag = 7'h01;
      end else begin
         for (int i = 0; i < 32; i++) stream[i] = 1'b0;
         len = 0;
         if (ki >= 0) begin
            for (int i = 0; i <= ki; i++) begin stream[len] = 1'b1; len++; end
            stream[len] = 1'b0; len++;
         end else begin
            for (int i = 0; i < -ki; i++) begin stream[len] = 1'b0; len++; end
            stream[len] = 1'b1; len++;
         end
         for (int i = 4; i >= 0; i--) begin stream[len] = f[i]; len++; end
         mag = '0;
         for (int i = 0; i < 7; i++) mag = {mag[5:0], stream[i]};
         guard  = stream[7];
         sticky = 1'b0;
         for (int i = 8; i < 32; i++) sticky = sticky | stream[i];
         if (guard && (sticky || mag[0]) && mag != 7'h7F) mag = mag + 7'd1;
      end
      p = {1'b0, mag};
      if (s) p = -p;
      return p;
   endfunction

   task automatic drive(input logic s, input logic [7:0] k, input logic [4:0] f,
                        input logic z, input logic n);
      in_sign = s;
      in_k    = k;
      in_frac = f;
      in_zero = z;
      in_nar  = n;
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      drive(v.sign, v.k, v.frac, v.zero, v.nar);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check({v.name, "_lat1_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({v.name, "_valid"}, 32'(out_valid), 32'd1);
      check(v.name, 32'(out_posit), 32'(v.expv));
   endtask

   initial begin
      int   sent;
      int   recv;
      int   cycles;
      logic pending;
      logic fire_in;
      logic fire_out;
      logic [7:0] exp_w;

      vecs[0]  = '{"k0",         1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 8'h40};
      vecs[1]  = '{"km1",        1'b0, 8'hFF, 5'b00000, 1'b0, 1'b0, 8'h20};
      vecs[2]  = '{"k0_neg",     1'b1, 8'h00, 5'b00000, 1'b0, 1'b0, 8'hC0};
      vecs[3]  = '{"k6",         1'b0, 8'h06, 5'b00000, 1'b0, 1'b0, 8'h7F};
      vecs[4]  = '{"k9",         1'b0, 8'h09, 5'b00000, 1'b0, 1'b0, 8'h7F};
      vecs[5]  = '{"km6",        1'b0, 8'hFA, 5'b00000, 1'b0, 1'b0, 8'h01};
      vecs[6]  = '{"km7",        1'b0, 8'hF9, 5'b00000, 1'b0, 1'b0, 8'h01};
      vecs[7]  = '{"km128",      1'b0, 8'h80, 5'b00000, 1'b0, 1'b0, 8'h01};
      vecs[8]  = '{"k127_neg",   1'b1, 8'h7F, 5'b00000, 1'b0, 1'b0, 8'h81};
      vecs[9]  = '{"k1_exact",   1'b0, 8'h01, 5'b00010, 1'b0, 1'b0, 8'h61};
      vecs[10] = '{"k1_tie_dn",  1'b0, 8'h01, 5'b00001, 1'b0, 1'b0, 8'h60};
      vecs[11] = '{"k1_tie_up",  1'b0, 8'h01, 5'b00011, 1'b0, 1'b0, 8'h62};
      vecs[12] = '{"k5_ones",    1'b0, 8'h05, 5'b11111, 1'b0, 1'b0, 8'h7F};
      vecs[13] = '{"zero",       1'b0, 8'h03, 5'b10101, 1'b1, 1'b0, 8'h00};
      vecs[14] = '{"nar",        1'b0, 8'h03, 5'b10101, 1'b0, 1'b1, 8'h80};
      vecs[15] = '{"nar_zero_s", 1'b1, 8'h00, 5'b00000, 1'b1, 1'b1, 8'h80};
      vecs[16] = '{"km6_rnd_s",  1'b1, 8'hFA, 5'b11111, 1'b0, 1'b0, 8'hFE};
      vecs[17] = '{"k2_sticky",  1'b0, 8'h02, 5'b10101, 1'b0, 1'b0, 8'h75};

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_posit", 32'(out_posit), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Backpressure: two words accepted, third stalls, then drain in order
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(1'b0, 8'h00, 5'b00000, 1'b0, 1'b0);
      #1 check("bp_rdy0", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 8'hFF, 5'b00000, 1'b0, 1'b0);
      #1 check("bp_rdy1", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 8'h01, 5'b00010, 1'b0, 1'b0);
      #1 check("bp_rdy2_stall", 32'(in_ready), 32'd0);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_posit", 32'(out_posit), 32'h40);
      @(negedge clk);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_posit", 32'(out_posit), 32'h40);
      out_ready = 1'b1;
      #1 check("bp_rdy_comb", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_out1", 32'(out_posit), 32'h20);
      @(negedge clk);
      check("bp_out2", 32'(out_posit), 32'h61);
      check("bp_out2_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("bp_drained", 32'(out_valid), 32'd0);

      // Randomized valid/ready against the model
      sent = 0;
      recv = 0;
      cycles = 0;
      pending = 1'b0;
      while (recv < NWORDS && cycles < 60000) begin
         @(negedge clk);
         if (!pending && sent < NWORDS) begin
            if ($urandom_range(0, 9) == 0) in_k = 8'($urandom_range(0, 255));
            else in_k = 8'($urandom_range(0, 16) - 8);
            in_sign = 1'($urandom_range(0, 1));
            in_frac = 5'($urandom_range(0, 31));
            in_zero = ($urandom_range(0, 15) == 0);
            in_nar  = ($urandom_range(0, 15) == 0);
            pending = 1'b1;
         end
         in_valid  = pending && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         fire_in  = in_valid & in_ready;
         fire_out = out_valid & out_ready;
         if (fire_out) begin
            if (sb.size() == 0) begin
               check("rand_extra_output", 32'(out_posit), 32'hFFFF_FFFF);
            end else begin
               exp_w = sb.pop_front();
               check("rand_word", 32'(out_posit), 32'(exp_w));
            end
            recv++;
         end
         if (fire_in) begin
            sb.push_back(model(in_sign, in_k, in_frac, in_zero, in_nar));
            pending = 1'b0;
            sent++;
         end
         cycles++;
      end
      check("rand_recv_count", 32'(recv), 32'(NWORDS));
      check("rand_sb_empty", 32'(sb.size()), 32'd0);

      // Reset with both stages full
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 8'h00, 5'b00000, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h00, 5'b00000, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("rstmid_full_valid", 32'(out_valid), 32'd1);
      check("rstmid_full_rdy", 32'(in_ready), 32'd0);
      #1 rst_n = 1'b0;
      #1 check("rstmid_async_valid", 32'(out_valid), 32'd0);
      check("rstmid_async_posit", 32'(out_posit), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1 check("rstmid_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstmid_no_stale", 32'(out_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit packer: the inverse of the regime/seed decode path.
- Takes an unpacked posit (sign, signed regime value k, exponent, fraction without hidden bit) and produces a BITS-wide posit with round-to-nearest-even and saturation.
- Sits at the output end of the posit datapath, after arithmetic units that work on the decoded (seed, shifted data) form.
- Valid/ready handshake on both sides; 2-stage pipeline.

Parameters:
- BITS, 32, posit width.
- ES, 0, exponent field width; 0 means no exponent field.
- FRAC_W, 29, input fraction width (BITS-3), MSB-aligned, hidden bit excluded.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  encoder can accept input this cycle.
- in_sign  input  1  sign of value (1 = negative).
- in_k  input  BITS  signed regime value (same encoding as the decoder seed: run of m ones gives k=m-1, run of m zeros gives k=-m).
- in_exp  input  max(ES,1)  unsigned exponent; ignored when ES=0.
- in_frac  input  FRAC_W  fraction bits.
- in_zero  input  1  value is zero.
- in_nar  input  1  value is NaR; has priority over in_zero.
- out_valid  output  1  posit output valid.
- out_ready  input  1  downstream accepts output.
- out_posit  output  BITS  encoded posit.

Behaviour:
- Reset (async, rst_n=0): all pipeline valid flags clear; out_valid=0, out_posit=0, in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards in-flight words, with no partial output.
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - Stage 2 advances when !s2_valid | out_ready. Stage 1 advances when s2 advances or !s2_valid.
  - in_ready = !s1_valid | (stage 1 advances). in_ready is combinational from out_ready; there is no combinational in_valid→out path.
  - While out_valid=1 and out_ready=0, out_posit and out_valid hold stable.
- Latency: 2 cycles with no stall. Throughput: 1 word/cycle. Order is preserved.
- Stage 1 (regime build and align):
  - k >= 0: regime = (k+1) ones followed by a single zero.
  - k < 0: regime = (-k) zeros followed by a single one.
  - Form the vector regime | exp (ES bits) | frac, left-justified in a W = BITS+ES+FRAC_W+1 bit field.
  - Register: body = top BITS-1 bits; guard = next bit; sticky = OR of all remaining bits.
  - Also register sign, zero, nar, and saturation flags.
- Stage 2 (round, saturate, negate):
  - Round up iff guard & (sticky | body[0]).
  - Saturation:
    - k > BITS-2, or an increment that would carry out of the all-ones body: body = all ones (maxpos).
    - k < -(BITS-2): body = 0…01 (minpos).
    - Rounding never produces zero or NaR from a nonzero input.
  - Result = {0, body}; if sign, result = two's complement of it.
  - nar → 1 followed by zeros (0x80000000 at default). zero (without nar) → all zeros. sign is ignored for both.
- Exact boundaries:
  - k = BITS-2: regime fills the body with no terminator → maxpos; exp and frac feed only guard and sticky.
  - k = -(BITS-2): BITS-2 zeros then a one → minpos before rounding.
- Arithmetic: in_k is treated as signed BITS-wide. Regime length is computed without overflow for all k in range [-2^(BITS-1), 2^(BITS-1)-1].

Test Plan (BITS=8, ES=0, FRAC_W=5 unless stated):
- Basic values: k=0, frac=0, sign=0 → 0x40; k=-1 → 0x20; k=0 with sign=1 → 0xC0. Each appears 2 cycles after acceptance.
- Saturation: k=6 → 0x7F; k=9 → 0x7F; k=-6 → 0x01; k=-7 → 0x01; k=-128 → 0x01; k=127 with sign=1 → 0x81.
- Rounding with k=1 (regime 110):
  - frac=00010 → 0x61 (exact).
  - frac=00001 → guard=1, sticky=0, lsb=0 → 0x60 (round to even, down).
  - frac=00011 → 0x62 (tie, lsb=1, rounds up).
  - k=5, frac=11111 → body all ones, no overflow → 0x7F.
- Special flags: in_zero=1 → 0x00. in_nar=1 → 0x80. in_nar=1 & in_zero=1 with sign=1 → 0x80.
- Backpressure: out_ready=0; present 3 words back-to-back.
  - Two are accepted, then in_ready=0 and out_posit stays stable.
  - Raise out_ready: outputs drain in order, one per cycle, and in_ready=1 in the same cycle.
  - Random valid/ready toggling over 10k words matches the reference model with no loss or duplication.
- Reset: assert rst_n=0 with both stages full → out_valid drops immediately (async). After release, no stale word is emitted and in_ready=1.
